// File: rtl/univ_shift_reg.sv
// Universal shift register: direct single-cycle ops plus a counted burst engine
// that applies one shift/rotate op N times with registered busy/done status.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] M_HOLD  = MODE_W'(0);
    localparam logic [MODE_W-1:0] M_SHL   = MODE_W'(1);
    localparam logic [MODE_W-1:0] M_SHR   = MODE_W'(2);
    localparam logic [MODE_W-1:0] M_ROL   = MODE_W'(3);
    localparam logic [MODE_W-1:0] M_ROR   = MODE_W'(4);
    localparam logic [MODE_W-1:0] M_ASR   = MODE_W'(5);
    localparam logic [MODE_W-1:0] M_LOAD  = MODE_W'(6);
    localparam logic [MODE_W-1:0] M_CLEAR = MODE_W'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [MODE_W-1:0] mode_r, mode_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              busy_nxt, done_nxt;

    // One step of the selected operation on the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [MODE_W-1:0] op,
        input logic [WIDTH-1:0]  cur,
        input logic              s,
        input logic [WIDTH-1:0]  ld
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            M_HOLD:  r = cur;
            M_SHL:   r = {cur[WIDTH-2:0], s};
            M_SHR:   r = {s, cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_LOAD:  r = ld;
            M_CLEAR: r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shifting/rotating modes can be repeated by the burst engine.
    function automatic logic is_burst_op(input logic [MODE_W-1:0] op);
        return (op >= M_SHL) && (op <= M_ASR);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            mode_r <= M_HOLD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            cnt    <= cnt_nxt;
            mode_r <= mode_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next state, datapath and status; status is derived from the next state
    // so busy/done come straight out of flops.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        mode_nxt  = mode_r;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start && is_burst_op(mode)) begin
                    mode_nxt  = mode;
                    cnt_nxt   = steps;
                    state_nxt = (steps == '0) ? DONE : RUN;
                end else if (en) begin
                    q_nxt = apply_op(mode, q, sin, pin);
                end
            end
            RUN: begin
                q_nxt   = apply_op(mode_r, q, sin, pin);
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus queues expected snapshots,
// a monitor pops and compares them at the scheduled sample points.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
        .start(start), .steps(steps), .q(q), .sout_msb(sout_msb),
        .sout_lsb(sout_lsb), .busy(busy), .done(done)
    );

    typedef struct {
        int               cyc;
        bit               ph;   // 0: at negedge, 1: just before next posedge
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   stim_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input bit ph, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed, input string nm);
        exp_t e;
        e.cyc = cyc; e.ph = ph; e.q = eq; e.busy = eb; e.done = ed; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_phase(input bit ph);
        exp_t e;
        while (exp_q.size() > 0 &&
               (exp_q[0].cyc < cyc || (exp_q[0].cyc == cyc && exp_q[0].ph <= ph))) begin
            e = exp_q.pop_front();
            total++;
            if (e.cyc != cyc || e.ph != ph) begin
                bad++;
                $display("FAIL %s stale sample: scheduled cyc=%0d ph=%0d, now cyc=%0d ph=%0d",
                         e.name, e.cyc, e.ph, cyc, ph);
            end else if (q !== e.q || busy !== e.busy || done !== e.done ||
                         sout_msb !== e.q[WIDTH-1] || sout_lsb !== e.q[0]) begin
                bad++;
                $display("FAIL %s cyc=%0d: got q=%h busy=%b done=%b msb=%b lsb=%b, want q=%h busy=%b done=%b msb=%b lsb=%b",
                         e.name, cyc, q, busy, done, sout_msb, sout_lsb,
                         e.q, e.busy, e.done, e.q[WIDTH-1], e.q[0]);
            end
        end
    endtask

    // Monitor: samples mid-cycle and again just before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            check_phase(1'b0);
            #4;
            check_phase(1'b1);
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0;
        pin = '0; start = 1'b0; steps = '0;

        // Reset state
        tick(); tick();
        expect_at(0, 10'h000, 0, 0, "reset");
        rst = 1'b1;
        tick();
        expect_at(0, 10'h000, 0, 0, "post_reset");

        // Direct load then rotate left
        en = 1'b1; mode = 3'd6; pin = 10'h2A5;
        tick(); expect_at(0, 10'h2A5, 0, 0, "load_2a5");
        mode = 3'd3;
        tick(); expect_at(0, 10'h14B, 0, 0, "rol_14b");
        en = 1'b0;

        // ASR burst, N=3
        en = 1'b1; mode = 3'd6; pin = 10'h200;
        tick(); expect_at(0, 10'h200, 0, 0, "load_200");
        en = 1'b0; start = 1'b1; mode = 3'd5; steps = 4'd3;
        tick(); expect_at(0, 10'h200, 1, 0, "asr_e0");
        start = 1'b0; mode = 3'd7;
        tick(); expect_at(0, 10'h300, 1, 0, "asr_e1");
        tick(); expect_at(0, 10'h380, 1, 0, "asr_e2");
        tick(); expect_at(0, 10'h3C0, 1, 1, "asr_e3");
        tick(); expect_at(0, 10'h3C0, 0, 0, "asr_idle");

        // SHL burst, N=WIDTH, with ignored start/en pulses while busy
        en = 1'b1; mode = 3'd7;
        tick(); expect_at(0, 10'h000, 0, 0, "clear");
        en = 1'b0; start = 1'b1; mode = 3'd1; steps = 4'd10; sin = 1'b1;
        tick(); expect_at(0, 10'h000, 1, 0, "shl_e0");
        for (int k = 1; k <= 10; k++) begin
            start = k[0]; en = k[0]; mode = k[0] ? 3'd7 : 3'd6;
            steps = 4'd1; pin = 10'h155;
            if (k == 10) begin
                start = 1'b0; en = 1'b0;
            end
            tick();
            expect_at(0, 10'((1 << k) - 1), 1, (k == 10), "shl_run");
        end
        tick(); expect_at(0, 10'h3FF, 0, 0, "shl_idle");

        // Zero-length burst
        sin = 1'b0; start = 1'b1; mode = 3'd2; steps = 4'd0;
        tick(); expect_at(0, 10'h3FF, 1, 1, "n0_e0");
        start = 1'b0;
        tick(); expect_at(0, 10'h3FF, 0, 0, "n0_idle");

        // ROR burst aborted by asynchronous reset after E3
        en = 1'b1; mode = 3'd6; pin = 10'h001;
        tick(); expect_at(0, 10'h001, 0, 0, "load_001");
        en = 1'b0; start = 1'b1; mode = 3'd4; steps = 4'd8;
        tick(); expect_at(0, 10'h001, 1, 0, "ror_e0");
        start = 1'b0;
        tick(); expect_at(0, 10'h200, 1, 0, "ror_e1");
        tick(); expect_at(0, 10'h100, 1, 0, "ror_e2");
        tick(); expect_at(0, 10'h080, 1, 0, "ror_e3");
        @(negedge clk); #1;
        rst = 1'b0;
        expect_at(1, 10'h000, 0, 0, "async_rst");
        tick(); expect_at(0, 10'h000, 0, 0, "rst_held");
        rst = 1'b1;
        tick(); expect_at(0, 10'h000, 0, 0, "rst_release");

        // Burst after abort behaves normally
        en = 1'b1; mode = 3'd6; pin = 10'h201;
        tick(); expect_at(0, 10'h201, 0, 0, "load_201");
        en = 1'b0; start = 1'b1; mode = 3'd3; steps = 4'd2;
        tick(); expect_at(0, 10'h201, 1, 0, "rol2_e0");
        start = 1'b0;
        tick(); expect_at(0, 10'h003, 1, 0, "rol2_e1");
        tick(); expect_at(0, 10'h006, 1, 1, "rol2_e2");
        tick(); expect_at(0, 10'h006, 0, 0, "rol2_idle");

        // Hold cases, clear, and start ignored for non-burst mode
        en = 1'b0; mode = 3'd7;
        tick(); expect_at(0, 10'h006, 0, 0, "en0_clear");
        en = 1'b1; mode = 3'd0;
        tick(); expect_at(0, 10'h006, 0, 0, "en1_hold");
        mode = 3'd7;
        tick(); expect_at(0, 10'h000, 0, 0, "en1_clear");
        start = 1'b1; mode = 3'd6; pin = 10'h155; steps = 4'd5;
        tick(); expect_at(0, 10'h155, 0, 0, "start_load_ignored");
        start = 1'b0; en = 1'b0;
        tick(); expect_at(0, 10'h155, 0, 0, "final_hold");

        tick(); tick();
        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            bad += exp_q.size();
            total += exp_q.size();
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus process never completes.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus incomplete at cyc=%0d, want completion", cyc);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "timeout");
        end
    end

endmodule
